// File: rtl/s1_irq_ctrl_rr_pkg.sv
// Shared definitions for the S1 interrupt controller: default sizing and FSM encoding.
package s1_irq_ctrl_rr_pkg;

  localparam int IRQ_N_DEFAULT    = 64;
  localparam int IRQ_ID_W_DEFAULT = 6;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } irq_state_e;

endpackage

// File: rtl/s1_irq_rr_arbiter.sv
// Combinational arbiter: lowest requesting index at or above the start point, else lowest overall.
module s1_irq_rr_arbiter #(
  parameter int N    = 64,
  parameter int ID_W = 6,
  parameter int RR   = 1
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] last,
  output logic            any,
  output logic [ID_W-1:0] winner
);

  logic [ID_W-1:0] start;
  logic            hi_any;
  logic            lo_any;
  logic [ID_W-1:0] hi_id;
  logic [ID_W-1:0] lo_id;

  // Explicit wrap so non-power-of-2 N never points past the last line.
  always_comb begin
    if (RR == 0) begin
      start = '0;
    end else if (last == ID_W'(N - 1)) begin
      start = '0;
    end else begin
      start = last + 1'b1;
    end
  end

  // Scanning downwards leaves the lowest qualifying index in each pass.
  always_comb begin
    hi_any = 1'b0;
    lo_any = 1'b0;
    hi_id  = '0;
    lo_id  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_any = 1'b1;
        lo_id  = ID_W'(i);
        if (i >= int'(start)) begin
          hi_any = 1'b1;
          hi_id  = ID_W'(i);
        end
      end
    end
  end

  assign any    = lo_any;
  assign winner = hi_any ? hi_id : lo_id;

endmodule

// File: rtl/s1_irq_ctrl_rr.sv
// S1 interrupt controller: synchronises IRQ lines, tracks edge/level pending state and
// presents one arbitrated source ID at a time until the bridge acknowledges it.
module s1_irq_ctrl_rr
  import s1_irq_ctrl_rr_pkg::*;
#(
  parameter int N_IRQ       = IRQ_N_DEFAULT,
  parameter int ID_W        = IRQ_ID_W_DEFAULT,
  parameter int SYNC_STAGES = 2,
  parameter int RR_PRIO     = 1
) (
  input  logic             sys_clock_i,
  input  logic             sys_reset_n_i,
  input  logic [N_IRQ-1:0] sys_irq_i,
  input  logic [N_IRQ-1:0] cfg_mask_i,
  input  logic [N_IRQ-1:0] cfg_edge_i,
  input  logic             irq_ack_i,
  output logic             irq_valid_o,
  output logic [ID_W-1:0]  irq_source_o,
  output logic [N_IRQ-1:0] irq_pending_o
);

  logic [N_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [N_IRQ-1:0] sync;
  logic [N_IRQ-1:0] prev;
  logic [N_IRQ-1:0] edge_q;
  logic [N_IRQ-1:0] pend;
  logic [N_IRQ-1:0] blk;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] mode_chg;
  logic [N_IRQ-1:0] ack_hit;
  logic [N_IRQ-1:0] blk_n;
  logic [N_IRQ-1:0] pend_n;
  logic [N_IRQ-1:0] eligible;
  logic [ID_W-1:0]  last;
  logic             arb_any;
  logic [ID_W-1:0]  arb_id;
  logic             ack_ok;
  irq_state_e       state;

  // Stage boundary: input synchroniser chain followed by the edge-detect flop.
  always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev   <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= sys_irq_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev   <= sync;
      edge_q <= cfg_edge_i;
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // An edge event arriving on the ack cycle survives the clear; level lines stay blocked
  // until they drop, so a held level fires once per assertion.
  always_comb begin
    ack_ok   = (state == ST_PRESENT) && irq_ack_i;
    ack_hit  = (N_IRQ'(1) << irq_source_o) & {N_IRQ{ack_ok}};
    rise     = sync & ~prev;
    mode_chg = cfg_edge_i ^ edge_q;
    blk_n    = (blk | ack_hit) & sync & ~cfg_edge_i & ~mode_chg;
    pend_n   = ((cfg_edge_i & ((pend & ~ack_hit) | rise)) |
                (~cfg_edge_i & sync & ~blk_n)) & ~mode_chg;
  end

  // Stage boundary: pending and level-block state.
  always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      pend <= '0;
      blk  <= '0;
    end else begin
      pend <= pend_n;
      blk  <= blk_n;
    end
  end

  assign eligible      = pend & ~cfg_mask_i;
  assign irq_pending_o = pend;

  s1_irq_rr_arbiter #(
    .N    (N_IRQ),
    .ID_W (ID_W),
    .RR   (RR_PRIO)
  ) u_arb (
    .req    (eligible),
    .last   (last),
    .any    (arb_any),
    .winner (arb_id)
  );

  // Stage boundary: presentation FSM; the ID is held until acked regardless of later masking.
  always_ff @(posedge sys_clock_i or negedge sys_reset_n_i) begin
    if (!sys_reset_n_i) begin
      state        <= ST_IDLE;
      irq_valid_o  <= 1'b0;
      irq_source_o <= '0;
      last         <= ID_W'(N_IRQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            irq_source_o <= arb_id;
            irq_valid_o  <= 1'b1;
            state        <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (irq_ack_i) begin
            last        <= irq_source_o;
            irq_valid_o <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: begin
          irq_valid_o <= 1'b0;
          state       <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_s1_irq_ctrl_rr.sv
// Directed bench for s1_irq_ctrl_rr: a fixed-priority and a round-robin instance share stimulus.
module tb_s1_irq_ctrl_rr;

  localparam int N  = 64;
  localparam int IW = 6;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq;
  logic [N-1:0]  mask;
  logic [N-1:0]  edge_cfg;
  logic          ack_f;
  logic          ack_r;
  logic          valid_f;
  logic          valid_r;
  logic [IW-1:0] src_f;
  logic [IW-1:0] src_r;
  logic [N-1:0]  pend_f;
  logic [N-1:0]  pend_r;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  s1_irq_ctrl_rr #(.N_IRQ(N), .ID_W(IW), .SYNC_STAGES(SS), .RR_PRIO(0)) dut_fix (
    .sys_clock_i   (clk),
    .sys_reset_n_i (rst_n),
    .sys_irq_i     (irq),
    .cfg_mask_i    (mask),
    .cfg_edge_i    (edge_cfg),
    .irq_ack_i     (ack_f),
    .irq_valid_o   (valid_f),
    .irq_source_o  (src_f),
    .irq_pending_o (pend_f)
  );

  s1_irq_ctrl_rr #(.N_IRQ(N), .ID_W(IW), .SYNC_STAGES(SS), .RR_PRIO(1)) dut_rr (
    .sys_clock_i   (clk),
    .sys_reset_n_i (rst_n),
    .sys_irq_i     (irq),
    .cfg_mask_i    (mask),
    .cfg_edge_i    (edge_cfg),
    .irq_ack_i     (ack_r),
    .irq_valid_o   (valid_r),
    .irq_source_o  (src_r),
    .irq_pending_o (pend_r)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq   = '0;
    ack_f = 1'b0;
    ack_r = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
  endtask

  task automatic pulse(input logic [N-1:0] v);
    irq = irq | v;
    tick();
    irq = irq & ~v;
  endtask

  task automatic wait_r(input string tag, input logic [IW-1:0] id);
    for (int k = 0; k < 12 && !valid_r; k++) tick();
    check(tag, {valid_r, src_r}, {1'b1, id});
  endtask

  task automatic wait_f(input string tag, input logic [IW-1:0] id);
    for (int k = 0; k < 12 && !valid_f; k++) tick();
    check(tag, {valid_f, src_f}, {1'b1, id});
  endtask

  task automatic ack_rr(input string tag);
    ack_r = 1'b1;
    tick();
    ack_r = 1'b0;
    check(tag, valid_r, 1'b0);
  endtask

  task automatic ack_fx(input string tag);
    ack_f = 1'b1;
    tick();
    ack_f = 1'b0;
    check(tag, valid_f, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    // Reset with every line high, then release and time the first presentation.
    rst_n    = 1'b0;
    irq      = '1;
    mask     = '0;
    edge_cfg = '0;
    ack_f    = 1'b0;
    ack_r    = 1'b0;
    repeat (3) tick();
    check("rst_valid", valid_r, 1'b0);
    check("rst_pend", pend_r, '0);
    check("rst_valid_fix", valid_f, 1'b0);
    rst_n = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!valid_r && n < 10);
    check("rst_latency", n, SS + 2);
    check("rst_first_id", src_r, 0);
    check("rst_latency_fix", valid_f, 1'b1);

    // Fixed priority: lines 3 and 5 pulse together.
    edge_cfg = (64'd1 << 3) | (64'd1 << 5);
    do_reset();
    pulse((64'd1 << 3) | (64'd1 << 5));
    wait_f("fix_first", 3);
    ack_fx("fix_ack3");
    tick();
    check("fix_second", {valid_f, src_f}, {1'b1, 6'd5});
    ack_fx("fix_ack5");
    repeat (3) tick();
    check("fix_idle", valid_f, 1'b0);
    check("fix_pend_clear", pend_f, '0);

    // Round-robin over held level lines 0, 1, 63 with pointer wrap.
    edge_cfg = '0;
    do_reset();
    irq = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 63);
    wait_r("rr_0", 0);
    ack_rr("rr_ack0");
    wait_r("rr_1", 1);
    ack_rr("rr_ack1");
    wait_r("rr_63", 63);
    ack_rr("rr_ack63");
    repeat (4) tick();
    check("rr_blocked", valid_r, 1'b0);
    irq = '0;
    repeat (4) tick();
    irq = (64'd1 << 0) | (64'd1 << 1) | (64'd1 << 63);
    wait_r("rr_wrap0", 0);
    ack_rr("rr_wrap_ack0");
    wait_r("rr_wrap1", 1);
    ack_rr("rr_wrap_ack1");
    irq = '0;

    // Masked edge line 7, unmask, then a new edge landing on the ack cycle.
    edge_cfg = 64'd1 << 7;
    mask     = 64'd1 << 7;
    do_reset();
    pulse(64'd1 << 7);
    repeat (5) tick();
    check("mask_pend", pend_r[7], 1'b1);
    check("mask_novalid", valid_r, 1'b0);
    mask = '0;
    wait_r("unmask", 7);
    irq[7] = 1'b1;
    tick();
    tick();
    ack_r = 1'b1;
    tick();
    ack_r  = 1'b0;
    irq[7] = 1'b0;
    check("setwins_valid", valid_r, 1'b0);
    check("setwins_pend", pend_r[7], 1'b1);
    wait_r("setwins_again", 7);
    ack_rr("setwins_ack");
    repeat (4) tick();
    check("edge7_done", {valid_r, pend_r[7]}, 2'b00);

    // Level line 9 fires once per assertion.
    edge_cfg = '0;
    do_reset();
    irq[9] = 1'b1;
    wait_r("lvl_first", 9);
    ack_rr("lvl_ack");
    repeat (6) tick();
    check("lvl_hold", {valid_r, pend_r[9]}, 2'b00);
    irq[9] = 1'b0;
    repeat (3) tick();
    irq[9] = 1'b1;
    wait_r("lvl_again", 9);
    ack_rr("lvl_ack2");
    irq = '0;

    // Asynchronous reset while presenting ID 12.
    edge_cfg = 64'd1 << 12;
    do_reset();
    pulse(64'd1 << 12);
    wait_r("rst_pres", 12);
    #2 rst_n = 1'b0;
    #1 check("async_rst", valid_r, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    check("post_rst_idle", valid_r, 1'b0);
    check("post_rst_pend", pend_r, '0);

    // Round-robin resumes after the last grant rather than at index 0.
    edge_cfg = (64'd1 << 2) | (64'd1 << 3) | (64'd1 << 4);
    do_reset();
    pulse(64'd1 << 3);
    wait_r("rr_grant3", 3);
    ack_rr("rr_ack3");
    pulse((64'd1 << 2) | (64'd1 << 4));
    wait_r("rr_after3", 4);
    ack_rr("rr_ack4");
    wait_r("rr_then2", 2);
    ack_rr("rr_ack2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
